aq_axi_sdma64_sched: RTL and testbench

In-order job scheduler that sits between software/register logic and the sdma64 write and read DMA engines. Queues up to 2^DEPTH_LOG2 transfer descriptors (direction, address, count, irq flag) and issues each one to the matching engine using the START/READY one-shot handshake. Retires each job on the engine's completion pulse and keeps completion and pending counters. Raises a sticky interrupt for jobs flagged for notification.

---
 rtl/aq_axi_sdma64_sched.sv | 198 +++++++++++++++++++
 tb/tb_aq_axi_sdma64_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_axi_sdma64_sched.sv
// In-order descriptor queue feeding the sdma64 write/read engines through a
// START/READY one-shot handshake, with retire counting and a sticky interrupt.
module aq_axi_sdma64_sched #(
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  JOB_VALID,
   output logic                  JOB_READY,
   input  logic                  JOB_DIR,
   input  logic [31:0]           JOB_ADRS,
   input  logic [31:0]           JOB_COUNT,
   input  logic                  JOB_IRQ,
   input  logic                  CLEAR,
   input  logic                  INT_CLEAR,
   output logic                  WR_START,
   output logic [31:0]           WR_ADRS,
   output logic [31:0]           WR_COUNT,
   input  logic                  WR_READY,
   input  logic                  WR_INT,
   output logic                  RD_START,
   output logic [31:0]           RD_ADRS,
   output logic [31:0]           RD_COUNT,
   input  logic                  RD_READY,
   input  logic                  RD_INT,
   output logic [DEPTH_LOG2:0]   PENDING,
   output logic [15:0]           DONE_COUNT,
   output logic                  BUSY,
   output logic                  INTERRUPT
);

   localparam int unsigned Depth = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   DepthL  = (DEPTH_LOG2 + 1)'(Depth);
   localparam logic [DEPTH_LOG2-1:0] PtrOne  = 1;
   localparam logic [DEPTH_LOG2:0]   PendOne = 1;

   typedef enum logic [1:0] {StIdle, StIssue, StRun} st_e;

   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]   pend_q, pend_d;
   logic                  mem_dir_q   [Depth];
   logic [31:0]           mem_adrs_q  [Depth];
   logic [31:0]           mem_count_q [Depth];
   logic                  mem_irq_q   [Depth];

   st_e         wr_st_q, wr_st_d, rd_st_q, rd_st_d;
   logic [31:0] wr_adrs_q, wr_adrs_d, wr_count_q, wr_count_d;
   logic [31:0] rd_adrs_q, rd_adrs_d, rd_count_q, rd_count_d;
   logic        wr_irq_q, wr_irq_d, rd_irq_q, rd_irq_d;
   logic [15:0] done_q, done_d;
   logic        int_q, int_d;

   logic        push, pop, head_valid, head_dir, head_irq, head_zero;
   logic [31:0] head_adrs, head_count;
   logic        wr_go, rd_go, zero_go, wr_ret, rd_ret, irq_hit;
   logic [1:0]  retire_n;

   assign head_valid = (pend_q != '0);
   assign head_dir   = mem_dir_q[rptr_q];
   assign head_adrs  = mem_adrs_q[rptr_q];
   assign head_count = mem_count_q[rptr_q];
   assign head_irq   = mem_irq_q[rptr_q];
   assign head_zero  = (head_count == 32'd0);

   assign JOB_READY = (pend_q != DepthL) && !CLEAR;
   assign push      = JOB_VALID && JOB_READY;

   // Only the head is examined; CLEAR suppresses any dispatch that cycle
   assign wr_go   = !CLEAR && head_valid && !head_dir && !head_zero &&
                    (wr_st_q == StIdle) && WR_READY;
   assign rd_go   = !CLEAR && head_valid && head_dir && !head_zero &&
                    (rd_st_q == StIdle) && RD_READY;
   assign zero_go = !CLEAR && head_valid && head_zero;
   assign pop     = wr_go || rd_go || zero_go;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      pend_d = pend_q;
      if (CLEAR) begin
         wptr_d = '0;
         rptr_d = '0;
         pend_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + PtrOne;
         if (pop)  rptr_d = rptr_q + PtrOne;
         if (push && !pop)      pend_d = pend_q + PendOne;
         else if (!push && pop) pend_d = pend_q - PendOne;
      end
   end

   always_comb begin
      wr_st_d    = wr_st_q;
      wr_adrs_d  = wr_adrs_q;
      wr_count_d = wr_count_q;
      wr_irq_d   = wr_irq_q;
      wr_ret     = 1'b0;
      unique case (wr_st_q)
         StIdle: if (wr_go) begin
            wr_st_d    = StIssue;
            wr_adrs_d  = head_adrs;
            wr_count_d = head_count;
            wr_irq_d   = head_irq;
         end
         StIssue: if (!WR_READY) wr_st_d = StRun;
         StRun: if (WR_INT) begin
            wr_st_d = StIdle;
            wr_ret  = 1'b1;
         end
         default: wr_st_d = StIdle;
      endcase
   end

   always_comb begin
      rd_st_d    = rd_st_q;
      rd_adrs_d  = rd_adrs_q;
      rd_count_d = rd_count_q;
      rd_irq_d   = rd_irq_q;
      rd_ret     = 1'b0;
      unique case (rd_st_q)
         StIdle: if (rd_go) begin
            rd_st_d    = StIssue;
            rd_adrs_d  = head_adrs;
            rd_count_d = head_count;
            rd_irq_d   = head_irq;
         end
         StIssue: if (!RD_READY) rd_st_d = StRun;
         StRun: if (RD_INT) begin
            rd_st_d = StIdle;
            rd_ret  = 1'b1;
         end
         default: rd_st_d = StIdle;
      endcase
   end

   always_comb begin
      retire_n = {1'b0, wr_ret} + {1'b0, rd_ret} + {1'b0, zero_go};
      done_d   = done_q + 16'(retire_n);
      irq_hit  = (wr_ret && wr_irq_q) || (rd_ret && rd_irq_q) || (zero_go && head_irq);
      int_d    = int_q;
      if (irq_hit)        int_d = 1'b1;
      else if (INT_CLEAR) int_d = 1'b0;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         pend_q     <= '0;
         wr_st_q    <= StIdle;
         rd_st_q    <= StIdle;
         wr_adrs_q  <= '0;
         wr_count_q <= '0;
         wr_irq_q   <= 1'b0;
         rd_adrs_q  <= '0;
         rd_count_q <= '0;
         rd_irq_q   <= 1'b0;
         done_q     <= '0;
         int_q      <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         pend_q     <= pend_d;
         wr_st_q    <= wr_st_d;
         rd_st_q    <= rd_st_d;
         wr_adrs_q  <= wr_adrs_d;
         wr_count_q <= wr_count_d;
         wr_irq_q   <= wr_irq_d;
         rd_adrs_q  <= rd_adrs_d;
         rd_count_q <= rd_count_d;
         rd_irq_q   <= rd_irq_d;
         done_q     <= done_d;
         int_q      <= int_d;
      end
   end

   // Descriptor storage needs no reset; occupancy gates every read
   always_ff @(posedge ACLK) begin
      if (push) begin
         mem_dir_q[wptr_q]   <= JOB_DIR;
         mem_adrs_q[wptr_q]  <= JOB_ADRS;
         mem_count_q[wptr_q] <= JOB_COUNT;
         mem_irq_q[wptr_q]   <= JOB_IRQ;
      end
   end

   assign WR_START   = (wr_st_q == StIssue);
   assign RD_START   = (rd_st_q == StIssue);
   assign WR_ADRS    = wr_adrs_q;
   assign WR_COUNT   = wr_count_q;
   assign RD_ADRS    = rd_adrs_q;
   assign RD_COUNT   = rd_count_q;
   assign PENDING    = pend_q;
   assign DONE_COUNT = done_q;
   assign BUSY       = head_valid || (wr_st_q != StIdle) || (rd_st_q != StIdle);
   assign INTERRUPT  = int_q;

endmodule

// File: tb/tb_aq_axi_sdma64_sched.sv
// Directed bench for aq_axi_sdma64_sched; the bench drives engine READY/INT by hand.
module tb_aq_axi_sdma64_sched;

   logic        ACLK, ARESETN;
   logic        JOB_VALID, JOB_READY, JOB_DIR, JOB_IRQ, CLEAR, INT_CLEAR;
   logic [31:0] JOB_ADRS, JOB_COUNT;
   logic        WR_START, WR_READY, WR_INT, RD_START, RD_READY, RD_INT;
   logic [31:0] WR_ADRS, WR_COUNT, RD_ADRS, RD_COUNT;
   logic [2:0]  PENDING;
   logic [15:0] DONE_COUNT;
   logic        BUSY, INTERRUPT;

   int errors = 0;
   int checks = 0;

   aq_axi_sdma64_sched #(.DEPTH_LOG2(2)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .JOB_VALID(JOB_VALID), .JOB_READY(JOB_READY), .JOB_DIR(JOB_DIR),
      .JOB_ADRS(JOB_ADRS), .JOB_COUNT(JOB_COUNT), .JOB_IRQ(JOB_IRQ),
      .CLEAR(CLEAR), .INT_CLEAR(INT_CLEAR),
      .WR_START(WR_START), .WR_ADRS(WR_ADRS), .WR_COUNT(WR_COUNT),
      .WR_READY(WR_READY), .WR_INT(WR_INT),
      .RD_START(RD_START), .RD_ADRS(RD_ADRS), .RD_COUNT(RD_COUNT),
      .RD_READY(RD_READY), .RD_INT(RD_INT),
      .PENDING(PENDING), .DONE_COUNT(DONE_COUNT), .BUSY(BUSY), .INTERRUPT(INTERRUPT)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic job(input logic dir, input logic [31:0] adrs, input logic [31:0] cnt,
                      input logic irq);
      JOB_VALID = 1'b1;
      JOB_DIR   = dir;
      JOB_ADRS  = adrs;
      JOB_COUNT = cnt;
      JOB_IRQ   = irq;
   endtask

   initial begin
      ARESETN = 1'b0; JOB_VALID = 1'b0; JOB_DIR = 1'b0; JOB_ADRS = '0; JOB_COUNT = '0;
      JOB_IRQ = 1'b0; CLEAR = 1'b0; INT_CLEAR = 1'b0;
      WR_READY = 1'b1; WR_INT = 1'b0; RD_READY = 1'b1; RD_INT = 1'b0;
      #12;
      chk("rst_job_ready", 32'(JOB_READY), 1);
      chk("rst_pending", 32'(PENDING), 0);
      chk("rst_done", 32'(DONE_COUNT), 0);
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_int", 32'(INTERRUPT), 0);
      chk("rst_wr_start", 32'(WR_START), 0);
      ARESETN = 1'b1;
      tick();

      // Single write job with irq
      job(1'b0, 32'h1000_0000, 32'h100, 1'b1);
      tick();
      JOB_VALID = 1'b0;
      chk("t1_pend1", 32'(PENDING), 1);
      chk("t1_start_early", 32'(WR_START), 0);
      tick();
      chk("t1_start", 32'(WR_START), 1);
      chk("t1_adrs", WR_ADRS, 32'h1000_0000);
      chk("t1_count", WR_COUNT, 32'h100);
      chk("t1_pend0", 32'(PENDING), 0);
      tick();
      chk("t1_start_held", 32'(WR_START), 1);
      WR_READY = 1'b0;
      tick();
      chk("t1_start_drop", 32'(WR_START), 0);
      chk("t1_busy_run", 32'(BUSY), 1);
      repeat (8) tick();
      WR_INT = 1'b1;
      tick();
      WR_INT = 1'b0;
      WR_READY = 1'b1;
      chk("t1_done", 32'(DONE_COUNT), 1);
      chk("t1_int", 32'(INTERRUPT), 1);
      chk("t1_busy_idle", 32'(BUSY), 0);
      chk("t1_adrs_hold", WR_ADRS, 32'h1000_0000);
      INT_CLEAR = 1'b1;
      tick();
      INT_CLEAR = 1'b0;
      chk("t1_int_clr", 32'(INTERRUPT), 0);
      WR_INT = 1'b1;  // stray pulse while idle
      tick();
      WR_INT = 1'b0;
      chk("t1_stray_int", 32'(DONE_COUNT), 1);

      // Fill the queue with the engine held not ready
      WR_READY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         job(1'b0, 32'h2000_0000 + 32'(i) * 32'h10, 32'd4, 1'b0);
         tick();
      end
      chk("t2_pend4", 32'(PENDING), 4);
      chk("t2_full", 32'(JOB_READY), 0);
      job(1'b0, 32'h2000_0040, 32'd4, 1'b0);
      tick();
      JOB_VALID = 1'b0;
      chk("t2_pend_full_push", 32'(PENDING), 4);
      for (int i = 0; i < 4; i++) begin
         WR_READY = 1'b1;
         tick();
         chk("t2_start", 32'(WR_START), 1);
         chk("t2_adrs", WR_ADRS, 32'h2000_0000 + 32'(i) * 32'h10);
         chk("t2_pend", 32'(PENDING), 32'(3 - i));
         WR_READY = 1'b0;
         tick();
         chk("t2_start_drop", 32'(WR_START), 0);
         WR_INT = 1'b1;
         tick();
         WR_INT = 1'b0;
      end
      WR_READY = 1'b1;
      chk("t2_done", 32'(DONE_COUNT), 5);
      chk("t2_int_noirq", 32'(INTERRUPT), 0);

      // W, R, W: concurrent engines, third job waits for the write retire
      job(1'b0, 32'h3000_0000, 32'd8, 1'b0);
      tick();
      job(1'b1, 32'h3100_0000, 32'd8, 1'b0);
      tick();
      chk("t3_wr_start", 32'(WR_START), 1);
      chk("t3_pend_a", 32'(PENDING), 1);
      job(1'b0, 32'h3200_0000, 32'd8, 1'b0);
      tick();
      JOB_VALID = 1'b0;
      chk("t3_rd_start", 32'(RD_START), 1);
      chk("t3_rd_adrs", RD_ADRS, 32'h3100_0000);
      chk("t3_wr_adrs", WR_ADRS, 32'h3000_0000);
      chk("t3_pend_b", 32'(PENDING), 1);
      WR_READY = 1'b0;
      RD_READY = 1'b0;
      tick();
      chk("t3_wr_run", 32'(WR_START), 0);
      chk("t3_rd_run", 32'(RD_START), 0);
      chk("t3_pend_blk", 32'(PENDING), 1);
      WR_INT = 1'b1;
      RD_INT = 1'b1;
      tick();
      WR_INT = 1'b0;
      RD_INT = 1'b0;
      chk("t3_done2", 32'(DONE_COUNT), 7);
      WR_READY = 1'b1;
      RD_READY = 1'b1;
      tick();
      chk("t3_w2_start", 32'(WR_START), 1);
      chk("t3_w2_adrs", WR_ADRS, 32'h3200_0000);
      chk("t3_pend0", 32'(PENDING), 0);
      WR_READY = 1'b0;
      tick();
      WR_INT = 1'b1;
      tick();
      WR_INT = 1'b0;
      WR_READY = 1'b1;
      chk("t3_done3", 32'(DONE_COUNT), 8);

      // Zero-count job retires without touching an engine
      job(1'b0, 32'h0, 32'd0, 1'b1);
      tick();
      JOB_VALID = 1'b0;
      chk("t4_pend1", 32'(PENDING), 1);
      tick();
      chk("t4_done", 32'(DONE_COUNT), 9);
      chk("t4_int", 32'(INTERRUPT), 1);
      chk("t4_pend0", 32'(PENDING), 0);
      chk("t4_no_start", 32'(WR_START), 0);
      job(1'b0, 32'h0, 32'd0, 1'b1);
      tick();
      JOB_VALID = 1'b0;
      INT_CLEAR = 1'b1;
      tick();
      chk("t4_set_wins", 32'(INTERRUPT), 1);
      chk("t4_done2", 32'(DONE_COUNT), 10);
      tick();
      INT_CLEAR = 1'b0;
      chk("t4_int_clr", 32'(INTERRUPT), 0);

      // CLEAR with three queued jobs and the first one running
      job(1'b0, 32'h4000_0000, 32'd16, 1'b0);
      tick();
      job(1'b0, 32'h4000_0010, 32'd16, 1'b0);
      tick();
      WR_READY = 1'b0;
      job(1'b0, 32'h4000_0020, 32'd16, 1'b0);
      tick();
      job(1'b0, 32'h4000_0030, 32'd16, 1'b0);
      tick();
      chk("t5_pend3", 32'(PENDING), 3);
      job(1'b0, 32'h4000_0040, 32'd16, 1'b0);
      CLEAR = 1'b1;
      #1;
      chk("t5_ready_clr", 32'(JOB_READY), 0);
      tick();
      CLEAR = 1'b0;
      JOB_VALID = 1'b0;
      chk("t5_pend0", 32'(PENDING), 0);
      chk("t5_busy_run", 32'(BUSY), 1);
      WR_INT = 1'b1;
      tick();
      WR_INT = 1'b0;
      chk("t5_done", 32'(DONE_COUNT), 11);
      WR_READY = 1'b1;
      tick();
      tick();
      chk("t5_no_start", 32'(WR_START), 0);
      chk("t5_idle", 32'(BUSY), 0);

      // Reset in the middle of a transfer
      job(1'b0, 32'h4100_0000, 32'd16, 1'b1);
      tick();
      JOB_VALID = 1'b0;
      tick();
      chk("t6_start", 32'(WR_START), 1);
      WR_READY = 1'b0;
      tick();
      ARESETN = 1'b0;
      #1;
      chk("t6_rst_start", 32'(WR_START), 0);
      chk("t6_rst_busy", 32'(BUSY), 0);
      chk("t6_rst_done", 32'(DONE_COUNT), 0);
      chk("t6_rst_ready", 32'(JOB_READY), 1);
      chk("t6_rst_adrs", WR_ADRS, 0);
      chk("t6_rst_pend", 32'(PENDING), 0);
      #3;
      ARESETN = 1'b1;
      WR_READY = 1'b1;
      job(1'b0, 32'h5000_0000, 32'd32, 1'b0);
      tick();
      JOB_VALID = 1'b0;
      tick();
      chk("t6_post_start", 32'(WR_START), 1);
      chk("t6_post_adrs", WR_ADRS, 32'h5000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
